// File: rtl/cke_sched.sv
// Multi-channel clock-enable scheduler: a shared prescaler base tick is divided per channel.
// Optional pending/interrupt logic is built when CKE_SCHED_IRQ_EN is defined.
module cke_sched #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int PRESCALE = 50,
  parameter int CW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          ena,
  input  logic          cfg_we,
  input  logic          cfg_stop,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_period,
  input  logic          cfg_oneshot,
`ifdef CKE_SCHED_IRQ_EN
  input  logic [N-1:0]  ack,
  output logic [N-1:0]  pend,
  output logic          irq,
`endif
  output logic          tick,
  output logic [N-1:0]  cke,
  output logic [N-1:0]  active
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  WONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  WZERO = {W{1'b0}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_e;

  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic          tick_r;

  st_e           state_r    [N];
  st_e           state_nx_s [N];
  logic [W-1:0]  cnt_r      [N];
  logic [W-1:0]  cnt_nx_s   [N];
  logic [W-1:0]  period_r   [N];
  logic [W-1:0]  period_nx_s[N];
  logic [N-1:0]  oneshot_r;
  logic [N-1:0]  oneshot_nx_s;
  logic [N-1:0]  fire_s;
  logic [N-1:0]  cke_nx_s;
  logic [N-1:0]  active_nx_s;
  logic [N-1:0]  cke_r;
  logic [N-1:0]  active_r;

  // Base tick is the last prescaler count of an enabled cycle.
  always_comb begin
    tick_s = ena & (presc_r == PMAX);
  end

  // Prescaler and registered tick output; only ena advances the count.
  always_ff @(posedge clk) begin
    if (rst_) begin
      presc_r <= {PW{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      tick_r <= tick_s;
      if (ena) begin
        if (presc_r == PMAX) begin
          presc_r <= {PW{1'b0}};
        end else begin
          presc_r <= presc_r + PONE;
        end
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_) begin
        state_r[i]  <= IDLE;
        cnt_r[i]    <= WZERO;
        period_r[i] <= WZERO;
      end else begin
        state_r[i]  <= state_nx_s[i];
        cnt_r[i]    <= cnt_nx_s[i];
        period_r[i] <= period_nx_s[i];
      end
    end
    if (rst_) begin
      oneshot_r <= {N{1'b0}};
    end else begin
      oneshot_r <= oneshot_nx_s;
    end
  end

  // Channel next-state: stop beats write, write beats the tick, then countdown/fire.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      logic hit_s;
      logic stop_s;
      logic wr_s;
      hit_s           = (32'(cfg_ch) == 32'(i));
      stop_s          = hit_s & cfg_stop;
      wr_s            = hit_s & cfg_we & ~cfg_stop;
      state_nx_s[i]   = state_r[i];
      cnt_nx_s[i]     = cnt_r[i];
      period_nx_s[i]  = period_r[i];
      oneshot_nx_s[i] = oneshot_r[i];
      fire_s[i]       = 1'b0;
      case (state_r[i])
        IDLE: begin
          if (wr_s && (cfg_period != WZERO)) begin
            state_nx_s[i]   = RUN;
            cnt_nx_s[i]     = cfg_period - WONE;
            period_nx_s[i]  = cfg_period;
            oneshot_nx_s[i] = cfg_oneshot;
          end else begin
            state_nx_s[i]   = IDLE;
          end
        end
        RUN: begin
          if (stop_s || (wr_s && (cfg_period == WZERO))) begin
            state_nx_s[i] = IDLE;
          end else if (wr_s) begin
            cnt_nx_s[i]     = cfg_period - WONE;
            period_nx_s[i]  = cfg_period;
            oneshot_nx_s[i] = cfg_oneshot;
          end else if (tick_s) begin
            if (cnt_r[i] == WZERO) begin
              fire_s[i] = 1'b1;
              if (oneshot_r[i]) begin
                state_nx_s[i] = IDLE;
              end else begin
                cnt_nx_s[i] = period_r[i] - WONE;
              end
            end else begin
              cnt_nx_s[i] = cnt_r[i] - WONE;
            end
          end else begin
            state_nx_s[i] = RUN;
          end
        end
        default: begin
          state_nx_s[i] = IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so active and a one-shot cke change on the same edge.
  always_comb begin
    cke_nx_s = fire_s;
    for (int i = 0; i < N; i++) begin
      active_nx_s[i] = (state_nx_s[i] == RUN);
    end
  end

  // Registered channel outputs.
  always_ff @(posedge clk) begin
    if (rst_) begin
      cke_r    <= {N{1'b0}};
      active_r <= {N{1'b0}};
    end else begin
      cke_r    <= cke_nx_s;
      active_r <= active_nx_s;
    end
  end

  assign tick   = tick_r;
  assign cke    = cke_r;
  assign active = active_r;

`ifdef CKE_SCHED_IRQ_EN
  logic [N-1:0] pend_r;
  logic [N-1:0] pend_nx_s;
  logic         irq_r;

  // A new pulse sets pend even when ack clears it in the same cycle.
  always_comb begin
    pend_nx_s = (pend_r & ~ack) | cke_nx_s;
  end

  // Pending flags and interrupt line.
  always_ff @(posedge clk) begin
    if (rst_) begin
      pend_r <= {N{1'b0}};
      irq_r  <= 1'b0;
    end else begin
      pend_r <= pend_nx_s;
      irq_r  <= |pend_nx_s;
    end
  end

  assign pend = pend_r;
  assign irq  = irq_r;
`endif

endmodule

// File: tb/tb_cke_sched.sv
// Self-checking bench for cke_sched: directed scenarios plus random traffic against a tick-count model.
module tb_cke_sched;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int P  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_ = 1'b1;
  logic          ena = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_stop = 1'b0;
  logic          cfg_oneshot = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [W-1:0]  cfg_period = '0;
  logic          tick;
  logic [N-1:0]  cke;
  logic [N-1:0]  active;
`ifdef CKE_SCHED_IRQ_EN
  logic [N-1:0]  ack = '0;
  logic [N-1:0]  pend;
  logic          irq;
`endif

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;
  int cyc   = 0;

  // reference model: base ticks still to wait per channel
  int           m_phase;
  bit           m_run [N];
  int           m_left[N];
  int           m_per [N];
  bit           m_os  [N];
  logic         m_tick;
  logic [N-1:0] m_cke;
  logic [N-1:0] m_act;
  logic [N-1:0] m_pend;

  cke_sched #(.N(N), .W(W), .PRESCALE(P), .CW(CW)) dut (
    .clk(clk), .rst_(rst_), .ena(ena), .cfg_we(cfg_we), .cfg_stop(cfg_stop),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
`ifdef CKE_SCHED_IRQ_EN
    .ack(ack), .pend(pend), .irq(irq),
`endif
    .tick(tick), .cke(cke), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit tk;
    if (rst_) begin
      m_phase = 0; m_tick = 1'b0; m_cke = '0; m_act = '0; m_pend = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 1'b0; m_left[i] = 0; m_per[i] = 0; m_os[i] = 1'b0;
      end
    end else begin
      tk = ena && (m_phase == P - 1);
      if (ena) m_phase = (m_phase + 1) % P;
      m_tick = tk;
      m_cke  = '0;
      for (int i = 0; i < N; i++) begin
        if (int'(cfg_ch) == i && cfg_stop) begin
          m_run[i] = 1'b0;
        end else if (int'(cfg_ch) == i && cfg_we) begin
          if (cfg_period == 0) begin
            m_run[i] = 1'b0;
          end else begin
            m_run[i] = 1'b1; m_left[i] = int'(cfg_period);
            m_per[i] = int'(cfg_period); m_os[i] = cfg_oneshot;
          end
        end else if (m_run[i] && tk) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_cke[i] = 1'b1;
            if (m_os[i]) m_run[i] = 1'b0;
            else m_left[i] = m_per[i];
          end
        end
        m_act[i] = m_run[i];
      end
`ifdef CKE_SCHED_IRQ_EN
      m_pend = (m_pend & ~ack) | m_cke;
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("tick", 32'(tick), 32'(m_tick));
    chk("cke", 32'(cke), 32'(m_cke));
    chk("active", 32'(active), 32'(m_act));
`ifdef CKE_SCHED_IRQ_EN
    chk("pend", 32'(pend), 32'(m_pend));
    chk("irq", 32'(irq), 32'(|m_pend));
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int ch, input int per, input bit os);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_period = W'(per); cfg_oneshot = os;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic stop(input int ch);
    cfg_stop = 1'b1; cfg_ch = CW'(ch);
    step();
    cfg_stop = 1'b0;
  endtask

  task automatic wait_cke(input int ch, input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (cke[ch]) begin
        t = cyc;
        break;
      end
    end
    chk("cke_timeout", 32'(t >= 0), 32'd1);
  endtask

  task automatic wait_tick(input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (tick) begin
        t = cyc;
        break;
      end
    end
    chk("tick_timeout", 32'(t >= 0), 32'd1);
  endtask

  initial begin
    int t0, t1, tw, cnt;
    logic [N-1:0] a_before;

    // reset state
    idle(3);
    chk("rst_outputs", 32'({tick, cke, active}), 32'd0);
    rst_ = 1'b0; ena = 1'b1;
    idle(2);

    // 1: periodic ch0 period 3, 12-cycle spacing, tick every 4
    wr(0, 3, 1'b0);
    chk("t1_active0", 32'(active[0]), 32'd1);
    wait_cke(0, 20, t0);
    for (int k = 1; k < 10; k++) begin
      step();
      chk("t1_width", 32'(cke[0]), 32'd0);
      wait_cke(0, 30, t1);
      chk("t1_spacing", 32'(t1 - t0), 32'd12);
      t0 = t1;
    end
    wait_tick(10, t0);
    for (int k = 0; k < 4; k++) begin
      wait_tick(10, t1);
      chk("t1_tick_spacing", 32'(t1 - t0), 32'd4);
      t0 = t1;
    end

    // 2: one-shot ch1 period 2
    wr(1, 2, 1'b1);
    tw = cyc;
    wait_cke(1, 20, t1);
    chk("t2_latency_ok", 32'((t1 - tw) >= 5 && (t1 - tw) <= 9), 32'd1);
    chk("t2_active_fall", 32'(active[1]), 32'd0);
    cnt = 0;
    repeat (100) begin step(); if (cke[1]) cnt++; end
    chk("t2_no_more", 32'(cnt), 32'd0);

    // 3: freeze for 20 cycles mid-period
    wait_cke(0, 20, t0);
    idle(5);
    ena = 1'b0;
    cnt = 0;
    repeat (20) begin step(); if (tick || cke != '0) cnt++; end
    ena = 1'b1;
    chk("t3_gap_quiet", 32'(cnt), 32'd0);
    wait_cke(0, 40, t1);
    chk("t3_resume", 32'(t1 - t0), 32'd32);

    // 4: stop beats write, period 0 stops, out-of-range channel ignored
    wr(2, 5, 1'b0);
    idle(7);
    cfg_we = 1'b1; cfg_stop = 1'b1; cfg_ch = 3'd2; cfg_period = 16'd5;
    step();
    cfg_we = 1'b0; cfg_stop = 1'b0;
    chk("t4_stop_wins", 32'(active[2]), 32'd0);
    cnt = 0;
    repeat (40) begin step(); if (cke[2]) cnt++; end
    chk("t4_no_cke2", 32'(cnt), 32'd0);
    wr(3, 4, 1'b0);
    idle(6);
    chk("t4_ch3_run", 32'(active[3]), 32'd1);
    wr(3, 0, 1'b0);
    chk("t4_ch3_stop", 32'(active[3]), 32'd0);
    wr(2, 2, 1'b0);
    a_before = active;
    wr(7, 3, 1'b1);
    chk("t4_bad_ch", 32'(active), 32'(a_before));
    cnt = 0;
    repeat (30) begin step(); if (cke[3]) cnt++; end
    chk("t4_ch3_quiet", 32'(cnt), 32'd0);

    // maximum period is accepted
    wr(1, 65535, 1'b0);
    idle(5);
    chk("max_period_run", 32'(active[1]), 32'd1);

    // 5: reset aborts everything
    wr(3, 5, 1'b0);
    idle(10);
    chk("t5_all_run", 32'(active), 32'hF);
    rst_ = 1'b1;
    step();
    rst_ = 1'b0;
    chk("t5_rst_out", 32'({tick, cke, active}), 32'd0);
    cnt = 0;
    repeat (200) begin step(); if (cke != '0 || active != '0) cnt++; end
    chk("t5_quiet", 32'(cnt), 32'd0);

`ifdef CKE_SCHED_IRQ_EN
    // 6: pend/irq with ack collisions
    wr(3, 3, 1'b0);
    wait_cke(3, 20, t0);
    chk("t6_pend_set", 32'(pend[3]), 32'd1);
    chk("t6_irq_set", 32'(irq), 32'd1);
    idle(11);
    ack = 4'b1000;
    step();
    ack = '0;
    chk("t6_cke_coll", 32'(cke[3]), 32'd1);
    chk("t6_set_wins", 32'(pend[3]), 32'd1);
    ack = 4'b1000;
    step();
    ack = '0;
    chk("t6_ack_clr", 32'(pend[3]), 32'd0);
    chk("t6_irq_clr", 32'(irq), 32'd0);
    stop(3);
`endif

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      int r;
      ena = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 99);
      if (r < 6) begin
        cfg_we = 1'b1; cfg_ch = CW'($urandom_range(0, 7));
        cfg_period = W'($urandom_range(0, 6)); cfg_oneshot = 1'($urandom_range(0, 1));
        cfg_stop = ($urandom_range(0, 7) == 0);
      end else if (r < 8) begin
        cfg_stop = 1'b1; cfg_ch = CW'($urandom_range(0, 7));
      end
`ifdef CKE_SCHED_IRQ_EN
      ack = N'($urandom_range(0, 15));
`endif
      step();
      cfg_we = 1'b0; cfg_stop = 1'b0;
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
